// File: rtl/gray_ctrl_pkg.sv
// Shared definitions for the Gray-counter sequencer: FSM state encoding,
// direction constants and Gray/binary conversion helpers.
package gray_ctrl_pkg;

    // Helpers work on a fixed maximum width; callers size-cast in and out.
    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_core.sv
// WIDTH-bit reflected-Gray register: steps up/down by one code or clears to 0,
// and flags the wrap step with a registered one-cycle pulse.
module gray_core
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    input  logic             dir,
    input  logic             clear,
    output logic [WIDTH-1:0] gray,
    output logic             wrap_pulse
);

    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] bin_cur, bin_nxt;
    logic             wrap_q, wrap_d;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        bin_cur = WIDTH'(gray2bin(GRAY_MAX_W'(gray_q)));
        // WIDTH-bit arithmetic gives the mod 2^WIDTH wrap for free.
        bin_nxt = (dir == DIR_DOWN) ? bin_cur - 1'b1 : bin_cur + 1'b1;
        gray_d  = gray_q;
        wrap_d  = 1'b0;
        if (clear) begin
            gray_d = '0;
        end else if (step_en) begin
            gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_nxt)));
            wrap_d = (dir == DIR_DOWN) ? (bin_cur == '0) : (bin_cur == '1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign gray       = gray_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Burst sequencer for a Gray counter: command handshake, RUN/PAUSE/DONE FSM and
// remaining-step counter. Define GRAY_STEP_CHECK_EN to build the single-bit-change checker.
module gray_seq_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             cmd_dir,
    input  logic             cmd_clear,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] gray_out,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             wrapped,
    output logic             step_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             dir_q, dir_d;
    logic             step_en;
    logic             clear_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            dir_q       <= DIR_UP;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_d       = cmd_dir;
                    remaining_d = cmd_len;
                    state_d     = (cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // abort beats pause beats step; abort keeps the unfinished count visible
                if (abort) begin
                    state_d = ST_DONE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (abort)       state_d = ST_DONE;
                else if (!pause) state_d = ST_RUN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        done      = (state_q == ST_DONE);
        step_en   = (state_q == ST_RUN) && !abort && !pause;
        clear_en  = cmd_ready && cmd_valid && cmd_clear;
    end

    gray_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .step_en   (step_en),
        .dir       (dir_q),
        .clear     (clear_en),
        .gray      (gray_out),
        .wrap_pulse(wrapped)
    );

    assign remaining = remaining_q;

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] diff;
    logic             step_err_q;

    // A commanded clear is a legal jump, so the history restarts at 0 with it.
    always_comb diff = gray_out ^ prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            step_err_q <= 1'b0;
        end else begin
            prev_q     <= clear_en ? '0 : gray_out;
            step_err_q <= step_err_q || ((diff & (diff - 1'b1)) != '0);
        end
    end

    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed self-checking bench for gray_seq_ctrl (WIDTH=4, CNT_W=8); expected
// Gray codes and timings are hand-computed tables.
module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic       cmd_dir;
    logic       cmd_clear;
    logic       pause;
    logic       abort;
    logic [3:0] gray_out;
    logic [7:0] remaining;
    logic       busy;
    logic       done;
    logic       wrapped;
    logic       step_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] up_seq [16];
    logic [31:0] dn_seq [3];
    logic [31:0] t5_seq [4];

    gray_seq_ctrl #(
        .WIDTH(4),
        .CNT_W(8)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len  (cmd_len),
        .cmd_dir  (cmd_dir),
        .cmd_clear(cmd_clear),
        .pause    (pause),
        .abort    (abort),
        .gray_out (gray_out),
        .remaining(remaining),
        .busy     (busy),
        .done     (done),
        .wrapped  (wrapped),
        .step_err (step_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic dir, input logic clr);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_dir   = dir;
        cmd_clear = clr;
        check("ready_before_accept", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
    endtask

    initial begin
        up_seq = '{32'h0, 32'h1, 32'h3, 32'h2, 32'h6, 32'h7, 32'h5, 32'h4,
                   32'hC, 32'hD, 32'hF, 32'hE, 32'hA, 32'hB, 32'h9, 32'h8};
        dn_seq = '{32'h8, 32'h9, 32'hB};
        t5_seq = '{32'h2, 32'h6, 32'h7, 32'h5};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_dir   = 1'b0;
        cmd_clear = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        check("rst_gray", 32'(gray_out), 0);
        check("rst_rem", 32'(remaining), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_wrap", 32'(wrapped), 0);
        check("rst_err", 32'(step_err), 0);

        // Full up cycle with wrap on the 16th step
        send_cmd(8'd16, 1'b0, 1'b1);
        check("t1_busy0", 32'(busy), 1);
        check("t1_rem0", 32'(remaining), 16);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("t1_gray", 32'(gray_out), up_seq[i % 16]);
            check("t1_rem", 32'(remaining), 32'(16 - i));
            check("t1_wrap", 32'(wrapped), 32'(i == 16));
            check("t1_done", 32'(done), 32'(i == 16));
        end
        tick();
        check("t1_ready_end", 32'(cmd_ready), 1);
        check("t1_done_end", 32'(done), 0);
        check("t1_wrap_end", 32'(wrapped), 0);

        // Down from 0: wraps to MSB-only code on the first step
        send_cmd(8'd3, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t2_gray", 32'(gray_out), dn_seq[i-1]);
            check("t2_rem", 32'(remaining), 32'(3 - i));
            check("t2_wrap", 32'(wrapped), 32'(i == 1));
            check("t2_done", 32'(done), 32'(i == 3));
        end
        tick();
        check("t2_ready_end", 32'(cmd_ready), 1);

        // Pause for 3 cycles after step 4
        send_cmd(8'd10, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t3_gray_pre", 32'(gray_out), up_seq[i]);
        end
        pause = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("t3_gray_hold", 32'(gray_out), 32'h6);
            check("t3_busy_hold", 32'(busy), 1);
            check("t3_rem_hold", 32'(remaining), 6);
        end
        pause = 1'b0;
        tick();
        check("t3_gray_resume", 32'(gray_out), 32'h6);
        check("t3_busy_resume", 32'(busy), 1);
        for (int i = 5; i <= 10; i++) begin
            tick();
            check("t3_gray_post", 32'(gray_out), up_seq[i]);
            check("t3_rem_post", 32'(remaining), 32'(10 - i));
            check("t3_busy_post", 32'(busy), 32'(i < 10));
            check("t3_done_post", 32'(done), 32'(i == 10));
        end
        tick();
        check("t3_ready_end", 32'(cmd_ready), 1);

        // Abort after step 2
        send_cmd(8'd8, 1'b0, 1'b1);
        tick();
        tick();
        check("t4_gray_pre", 32'(gray_out), 32'h3);
        abort = 1'b1;
        tick();
        check("t4_gray_abort", 32'(gray_out), 32'h3);
        check("t4_done", 32'(done), 1);
        check("t4_rem", 32'(remaining), 6);
        check("t4_busy", 32'(busy), 0);
        abort = 1'b0;
        tick();
        check("t4_ready", 32'(cmd_ready), 1);
        check("t4_done_end", 32'(done), 0);
        check("t4_gray_end", 32'(gray_out), 32'h3);

        // Zero-length command
        send_cmd(8'd0, 1'b0, 1'b0);
        check("t5_done0", 32'(done), 1);
        check("t5_gray0", 32'(gray_out), 32'h3);
        check("t5_busy0", 32'(busy), 0);
        check("t5_ready0", 32'(cmd_ready), 0);
        tick();
        check("t5_ready1", 32'(cmd_ready), 1);
        check("t5_done1", 32'(done), 0);

        // cmd_valid held high during RUN and DONE is not accepted
        cmd_valid = 1'b1;
        cmd_len   = 8'd4;
        cmd_dir   = 1'b0;
        cmd_clear = 1'b0;
        tick();
        cmd_len = 8'd9;
        check("t5_ready_run", 32'(cmd_ready), 0);
        check("t5_rem_acc", 32'(remaining), 4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t5_gray", 32'(gray_out), t5_seq[i-1]);
            check("t5_rem", 32'(remaining), 32'(4 - i));
            check("t5_ready", 32'(cmd_ready), 0);
            check("t5_done", 32'(done), 32'(i == 4));
        end
        tick();
        check("t5_ready_idle", 32'(cmd_ready), 1);
        check("t5_busy_idle", 32'(busy), 0);
        check("t5_rem_idle", 32'(remaining), 0);
        check("t5_gray_idle", 32'(gray_out), 32'h5);
        cmd_valid = 1'b0;

        // Reset in the middle of a burst
        send_cmd(8'd10, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("t6_gray", 32'(gray_out), up_seq[i]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_gray_rst", 32'(gray_out), 0);
        check("t6_busy_rst", 32'(busy), 0);
        check("t6_done_rst", 32'(done), 0);
        check("t6_ready_rst", 32'(cmd_ready), 1);
        check("t6_rem_rst", 32'(remaining), 0);
        tick();
        check("t6_done_after", 32'(done), 0);

`ifdef GRAY_STEP_CHECK_EN
        force u_dut.u_core.gray_q = 4'h3;
        tick();
        release u_dut.u_core.gray_q;
        check("sc_set", 32'(step_err), 1);
        tick();
        check("sc_sticky", 32'(step_err), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sc_clear", 32'(step_err), 0);
`else
        check("step_err_off", 32'(step_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
